// File: rtl/gd_result_collector.sv
// gd_result_collector: captures one optimizer result per done_op rising edge
// and tracks the lowest z_min (with its coordinates) across a multi-start sweep.
// Optional feature macro: GD_COLLECT_CONVERGED_ONLY_EN -- when defined, only
// runs whose converged flag was set may update the best result.
module gd_result_collector #(
    parameter int unsigned NUM_RUNS = 49,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                done_op,
    input  logic [31:0]         z_min,
    input  logic [7:0]          final_a,
    input  logic [7:0]          final_b,
    input  logic [7:0]          final_c,
    input  logic [7:0]          final_d,
    input  logic                converged,
    output logic                capture_ack,
    output logic [31:0]         best_z,
    output logic [7:0]          best_a,
    output logic [7:0]          best_b,
    output logic [7:0]          best_c,
    output logic [7:0]          best_d,
    output logic [CNT_W-1:0]    best_run,
    output logic [CNT_W-1:0]    run_count,
    output logic                best_valid,
    output logic                sweep_done
);

    localparam logic [31:0] Z_INIT = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_done_q;
    logic               r_pend;
    logic               r_ack;
    logic               r_sweep_done;

    logic signed [31:0] r_sh_z;
    logic [7:0]         r_sh_a;
    logic [7:0]         r_sh_b;
    logic [7:0]         r_sh_c;
    logic [7:0]         r_sh_d;

    logic signed [31:0] r_best_z;
    logic [7:0]         r_best_a;
    logic [7:0]         r_best_b;
    logic [7:0]         r_best_c;
    logic [7:0]         r_best_d;
    logic [CNT_W-1:0]   r_best_run;
    logic [CNT_W-1:0]   r_run_count;
    logic               r_best_valid;

    logic               w_sync_clr;
    logic               w_rise;
    logic               w_take;
    logic               w_acc;
    logic               w_better;
    logic [CNT_W-1:0]   w_run_nxt;

    assign w_sync_clr = rst | clear;
    assign w_rise     = done_op & ~r_done_q;
    assign w_take     = (r_state == S_IDLE) && (w_rise || r_pend);
    assign w_run_nxt  = r_run_count + CNT_W'(1);
    // Strict less-than so a tie keeps the earlier run.
    assign w_better   = ~r_best_valid || (r_sh_z < r_best_z);

`ifdef GD_COLLECT_CONVERGED_ONLY_EN
    logic r_sh_conv;
    assign w_acc = r_sh_conv;
`else
    logic w_unused_converged;
    assign w_unused_converged = converged;
    assign w_acc = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (w_sync_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise || r_pend) w_state_nxt = S_CMP;
            S_CMP:   w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = (r_run_count == CNT_W'(NUM_RUNS)) ? S_DONE : S_IDLE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Edge detect, pending queue and registered status pulses
    always_ff @(posedge clk) begin
        if (w_sync_clr) begin
            r_done_q     <= 1'b0;
            r_pend       <= 1'b0;
            r_ack        <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_done_q     <= done_op;
            r_ack        <= (w_state_nxt == S_ACK);
            r_sweep_done <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE:  r_pend <= 1'b0;
                S_DONE:  r_pend <= 1'b0;
                default: if (w_rise) r_pend <= 1'b1;
            endcase
        end
    end

    // Shadow capture of the live result at the capture edge
    always_ff @(posedge clk) begin
        if (w_sync_clr) begin
            r_sh_z    <= '0;
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_sh_c    <= '0;
            r_sh_d    <= '0;
`ifdef GD_COLLECT_CONVERGED_ONLY_EN
            r_sh_conv <= 1'b0;
`endif
        end else if (w_take) begin
            r_sh_z    <= z_min;
            r_sh_a    <= final_a;
            r_sh_b    <= final_b;
            r_sh_c    <= final_c;
            r_sh_d    <= final_d;
`ifdef GD_COLLECT_CONVERGED_ONLY_EN
            r_sh_conv <= converged;
`endif
        end
    end

    // Run counting and best-result update in CMP
    always_ff @(posedge clk) begin
        if (w_sync_clr) begin
            r_best_z     <= Z_INIT;
            r_best_a     <= '0;
            r_best_b     <= '0;
            r_best_c     <= '0;
            r_best_d     <= '0;
            r_best_run   <= '0;
            r_run_count  <= '0;
            r_best_valid <= 1'b0;
        end else if (r_state == S_CMP) begin
            r_run_count <= w_run_nxt;
            if (w_acc && w_better) begin
                r_best_z     <= r_sh_z;
                r_best_a     <= r_sh_a;
                r_best_b     <= r_sh_b;
                r_best_c     <= r_sh_c;
                r_best_d     <= r_sh_d;
                r_best_run   <= w_run_nxt;
                r_best_valid <= 1'b1;
            end
        end
    end

    assign capture_ack = r_ack;
    assign sweep_done  = r_sweep_done;
    assign best_z      = r_best_z;
    assign best_a      = r_best_a;
    assign best_b      = r_best_b;
    assign best_c      = r_best_c;
    assign best_d      = r_best_d;
    assign best_run    = r_best_run;
    assign run_count   = r_run_count;
    assign best_valid  = r_best_valid;

endmodule

// File: doc/gd_result_collector.md
# gd_result_collector

Receiving end of the optimizer result interface. It watches `done_op`, captures `z_min`, the four final coordinates and the convergence flag once per run, and keeps the best (lowest) minimum seen across a multi-start sweep of `NUM_RUNS` runs. It returns a one-cycle `capture_ack` to the sweep initiator, which uses it to deassert `start_op` and begin the next run. It sits beside the gradient-descent core and replaces manual result inspection in sweep benches.

## Interface
- `NUM_RUNS`, 49: runs per sweep; range 1..255.
- `CNT_W`, 8: width of the run counters; must satisfy 2^CNT_W > NUM_RUNS.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous sweep restart; same effect as `rst`.
- `done_op` in 1: optimizer done level; held high until the initiator drops `start_op`.
- `z_min` in 32: signed Q24.8 minimum of the finished run.
- `final_a`, `final_b`, `final_c`, `final_d` in 8 each: signed integer coordinates at that minimum.
- `converged` in 1: optimizer convergence flag for the run.
- `capture_ack` out 1: one-cycle pulse meaning the result has been absorbed.
- `best_z` out 32: signed Q24.8 lowest accepted `z_min`.
- `best_a`, `best_b`, `best_c`, `best_d` out 8 each: coordinates belonging to `best_z`.
- `best_run` out CNT_W: 1-based index of the run that produced `best_z`.
- `run_count` out CNT_W: runs captured so far.
- `best_valid` out 1: at least one run has been accepted.
- `sweep_done` out 1: `NUM_RUNS` runs captured.

## Operation
- **Reset / clear values:**
  - `best_z` = 32'h7FFF_FFFF.
  - All other outputs, `done_q` and `pend` = 0.
  - State = IDLE.
  - `clear` has the same effect as `rst`, and `rst`/`clear` win over every other event in the same cycle.
- **Edge detect:** `done_q` registers `done_op`. `rise = done_op & ~done_q`.
- **Pending flag:** a `rise` seen outside IDLE sets `pend`. `pend` is serviced, and cleared, on the next cycle in IDLE.
- **FSM states:** IDLE, CMP, ACK, DONE.
- **IDLE:**
  - On `rise | pend`, load shadow registers from the live inputs and go to CMP.
  - Otherwise stay in IDLE.
- **CMP:**
  - `run_count` += 1.
  - Compute `acc` (see Configuration).
  - If `acc` and (`~best_valid` | shadow_z <s `best_z`): update `best_*`, set `best_run` = new `run_count`, set `best_valid` = 1.
  - Go to ACK.
- **ACK:**
  - `capture_ack` = 1 for this cycle only.
  - Go to DONE if `run_count` == `NUM_RUNS`, else IDLE.
- **DONE:**
  - `sweep_done` = 1.
  - `done_op` edges are ignored and `pend` is held at 0.
  - Leave DONE only via `rst` or `clear`.
- **Compare rules:**
  - Full 32-bit signed compare.
  - Ties keep the earlier run (strict less-than).
- **Constraints:** `run_count` never exceeds `NUM_RUNS`, so no wrap is possible.
- **Level hold:** a `done_op` held high over many cycles produces exactly one capture.

## Timing
- **Capture edge:** the edge E at which IDLE samples `done_op`=1 with `done_q`=0. Inputs must be stable at E; they are don't-care afterwards.
- **E+1:** `best_*`, `run_count` and `best_valid` take their new values.
- **Cycle after E+1:** `capture_ack` is high, i.e. 2 cycles after the capture edge. It drops at E+2.
- **Sweep completion:** `sweep_done` rises at E+2 of the final run.
- **Minimum capture spacing:** 3 cycles. A faster second rising edge is not lost; it is queued in `pend`. Only one run can be queued; further edges while `pend` is set are merged.
- **Reset mid-run:** a `rst` or `clear` during CMP/ACK drops the in-flight result. No `capture_ack` is issued for it.

## Configuration
- **Macro:** `GD_COLLECT_CONVERGED_ONLY_EN`.
- **Defined:** `acc` = shadow_converged.
  - Runs that did not converge still increment `run_count` and still get `capture_ack`.
  - They never update `best_*`.
  - If no run converges, `best_valid` stays 0 at `sweep_done`.
- **Undefined:** `acc` = 1. The `converged` input is ignored.

## Test plan
- **Single run:** reset, then `done_op` rises with `z_min`=32'hFFFF_FF00 (−1.0) and a..d = 3,−2,1,0.
  - Two cycles later `capture_ack` pulses.
  - `best_z` = FFFF_FF00, `best_run` = 1, `run_count` = 1, `best_valid` = 1.
- **Sequence with tie:** 3 runs with `z_min` = 0x0000_0200, 0xFFFF_FF80, 0xFFFF_FF80.
  - `best_z` = FFFF_FF80 and `best_run` = 2 (the tie keeps run 2).
- **Hold and sweep completion:** `NUM_RUNS`=4, `done_op` held high 20 cycles per run.
  - Exactly 4 acks.
  - `sweep_done` = 1 after the 4th.
  - A 5th `done_op` rise leaves `run_count` = 4 and produces no ack.
- **Back-to-back edges:** `done_op` pulses high one cycle on consecutive edges E and E+2.
  - Both are captured via `pend`.
  - `run_count` = 2 and two acks are seen, 3 cycles apart.
- **Clear mid-flight:** assert `clear` in the CMP cycle.
  - No ack.
  - All outputs return to reset values, with `best_z` = 7FFF_FFFF.
- **Macro defined:** runs `{z=-5.0, converged=0}` then `{z=-1.0, converged=1}`.
  - `best_z` = FFFF_FF00, `best_run` = 2.
  - With the macro undefined: `best_z` = FFFF_FB00, `best_run` = 1.
